// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   NIB_W   : width of the arithmetic slice
//   state_e : controller FSM encoding (ST_IDLE, ST_RUN, ST_DONE)
package addsub_seq_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational NIB_W-bit adder slice. Any subtract inversion is applied by the caller.
// Ports:
//   x   : first operand nibble
//   y   : second operand nibble (already inverted for subtract)
//   cin : carry in
//   s   : sum nibble
//   co  : carry out
module nibble_addsub
    import addsub_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    always_comb begin
        {co, s} = {1'b0, x} + {1'b0, y} + {{NIB_W{1'b0}}, cin};
    end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// W-bit add/subtract built from one NIB_W-bit slice, stepped LSB nibble first over NIBBLES
// cycles with the carry held in a register between steps.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : operation request, accepted when busy=0
//   sub        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b       : operands (sampled with start)
//   busy       : operation in progress
//   done       : one-cycle pulse when result/cout/ovf are valid
//   result     : sum/difference, held until the next accepted start
//   cout       : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        : two's-complement signed overflow
module addsub_seq_ctrl
    import addsub_seq_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned W = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic [W-1:0]       result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_co;
    logic               ovf_calc;

    always_comb begin
        a_nib = a_q[idx_q * NIB_W +: NIB_W];
        b_nib = b_q[idx_q * NIB_W +: NIB_W] ^ {NIB_W{sub_q}};
    end

    nibble_addsub u_slice (
        .x   (a_nib),
        .y   (b_nib),
        .cin (carry_q),
        .s   (slice_s),
        .co  (slice_co)
    );

    // Only meaningful on the final nibble, where slice_s holds the result MSB.
    always_comb begin
        ovf_calc = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (slice_s[NIB_W-1] != a_q[W-1]);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            // DONE accepts start exactly like IDLE so ops can run back-to-back.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub;  // +1 of the two's-complement negate
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                result_d[idx_q * NIB_W +: NIB_W] = slice_s;
                carry_d = slice_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_co;
                    ovf_d   = ovf_calc;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        busy   = busy_q;
        done   = done_q;
        result = result_q;
        cout   = cout_q;
        ovf    = ovf_q;
    end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl (NIBBLES=4, W=16). The driver pushes expected
// {result, cout, ovf} on each issued op; the monitor pops and compares on every done pulse.
// Driver-side observations (busy length, reset values, held results) are queued to the
// monitor as well, so a single process owns the counters.
module tb_addsub_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    addsub_seq_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected done responses: {result, cout, ovf}.
    logic [17:0] exp_q[$];
    // Driver observations to be compared by the monitor.
    string       chk_name[$];
    logic [31:0] chk_act[$];
    logic [31:0] chk_exp[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor: sample on the falling edge, away from the active edge.
    initial begin
        logic [17:0] e;
        logic [17:0] got;
        string       n;
        logic [31:0] av;
        logic [31:0] ev;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                tests_run++;
                got = {result, cout, ovf};
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_done: got result=%h cout=%b ovf=%b, none expected",
                             result, cout, ovf);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        tests_failed++;
                        $display("FAIL done_result: got result=%h cout=%b ovf=%b, want result=%h cout=%b ovf=%b",
                                 got[17:2], got[1], got[0], e[17:2], e[1], e[0]);
                    end
                end
            end
            while (chk_act.size() > 0) begin
                n  = chk_name.pop_front();
                av = chk_act.pop_front();
                ev = chk_exp.pop_front();
                tests_run++;
                if (av !== ev) begin
                    tests_failed++;
                    $display("FAIL %s: got %h, want %h", n, av, ev);
                end
            end
        end
    end

    task automatic push_chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        chk_name.push_back(n);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and follow it to completion. Returns with the DUT in DONE (busy=0).
    // With disturb set, a second start plus new operands are driven mid-operation.
    task automatic run_op(input string n, input logic s, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] er, input logic ec,
                          input logic eo, input bit disturb);
        int cyc;
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        start = 1'b1;
        sub   = s;
        a     = av;
        b     = bv;
        exp_q.push_back({er, ec, eo});
        tick();
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
        sub   = ~s;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 20) begin
            cyc++;
            if (disturb && cyc == 2) begin
                start = 1'b1;
                a     = 16'h5555;
                b     = 16'hAAAA;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        push_chk({n, "_busy_cycles"}, 32'(cyc), 32'd4);
    endtask

    initial begin
        int cyc;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        rst_n = 1'b0;
        #12;
        push_chk("reset_outputs", {13'd0, busy, done, cout, ovf, result}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // 1: plain add, then verify outputs hold through idle cycles.
        run_op("t1_add", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        push_chk("t1_hold", {14'd0, cout, ovf, result}, {14'd0, 1'b0, 1'b0, 16'h2201});

        // 2: subtract with borrow.
        run_op("t2_sub", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tick();

        // 3: signed overflow and unsigned carry-out.
        run_op("t3_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        tick();
        run_op("t3_carry", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick();

        // 4: subtract overflow, then next op started straight from DONE.
        run_op("t4_sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("t4_b2b", 1'b0, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        run_op("t4_b2b_sub", 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 1'b0);
        tick();

        // 5: start and operand changes while busy are ignored.
        run_op("t5_ignore", 1'b0, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        push_chk("t5_busy_after", {31'd0, busy}, 32'd0);

        // 6: reset during RUN discards the op (no expectation pushed).
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        push_chk("t6_reset_mid_run", {13'd0, busy, done, cout, ovf, result}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_op("t6_after_reset", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
        tick();

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        push_chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
